// File: rtl/pkg_generador_pulsos.sv
// Shared types and helpers for the multi-channel tick strobe generator.
package pkg_generador_pulsos;

  typedef enum logic {IDLE, RUN} estado_t;
  typedef enum logic {PERIODICO, UN_DISPARO} modo_t;

  // Width of the channel index port; a single channel still gets a 1-bit index.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/module_canal_pulsos.sv
// One strobe channel: period counter, live/shadow configuration and IDLE/RUN FSM.
module module_canal_pulsos
  import pkg_generador_pulsos::*;
#(
  parameter int unsigned CNT_W          = 25,
  parameter int unsigned DEFAULT_PERIOD = 20_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  output logic             tick,
  output logic             busy
);

  localparam logic [CNT_W-1:0] PER_RST = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] UNO     = CNT_W'(1);

  estado_t          state, state_d;
  modo_t            mode, mode_d, shadow_mode, shadow_mode_d, cfg_mode, apply_mode;
  logic [CNT_W-1:0] cnt, cnt_d, period, period_d, shadow, shadow_d, apply_period;
  logic             pend, pend_d, tick_q, tick_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      period      <= PER_RST;
      mode        <= PERIODICO;
      shadow      <= PER_RST;
      shadow_mode <= PERIODICO;
      pend        <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      period      <= period_d;
      mode        <= mode_d;
      shadow      <= shadow_d;
      shadow_mode <= shadow_mode_d;
      pend        <= pend_d;
      tick_q      <= tick_d;
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    period_d      = period;
    mode_d        = mode;
    shadow_d      = shadow;
    shadow_mode_d = shadow_mode;
    pend_d        = pend;
    tick_d        = 1'b0;
    cfg_mode      = cfg_oneshot ? UN_DISPARO : PERIODICO;
    // A write in the wrap cycle beats an older pending shadow value.
    apply_period  = cfg_we ? cfg_period : (pend ? shadow : period);
    apply_mode    = cfg_we ? cfg_mode : (pend ? shadow_mode : mode);

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (cfg_we) begin
          period_d = cfg_period;
          mode_d   = cfg_mode;
        end
        if (en && (period != '0) && ((mode == PERIODICO) || start))
          state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d  = IDLE;
          cnt_d    = '0;
          pend_d   = 1'b0;
          period_d = apply_period;
          mode_d   = apply_mode;
        end else if (cnt == period - UNO) begin
          tick_d   = 1'b1;
          cnt_d    = '0;
          pend_d   = 1'b0;
          period_d = apply_period;
          mode_d   = apply_mode;
          if ((mode == UN_DISPARO) || (apply_period == '0))
            state_d = IDLE;
        end else begin
          cnt_d = cnt + UNO;
          if (cfg_we) begin
            shadow_d      = cfg_period;
            shadow_mode_d = cfg_mode;
            pend_d        = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick = tick_q;
  assign busy = (state == RUN);

endmodule

// File: rtl/module_generador_pulsos_multicanal.sv
// N_CH independent programmable tick strobe channels with a shared config port.
module module_generador_pulsos_multicanal
  import pkg_generador_pulsos::*;
#(
  parameter  int unsigned N_CH           = 4,
  parameter  int unsigned CNT_W          = 25,
  parameter  int unsigned DEFAULT_PERIOD = 20_000_000,
  localparam int unsigned CH_IDX_W       = ch_idx_w(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic                cfg_oneshot,
  input  logic [N_CH-1:0]     ch_en,
  input  logic [N_CH-1:0]     start,
  output logic [N_CH-1:0]     tick,
  output logic [N_CH-1:0]     busy
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Indices at or above N_CH match no channel, so such writes are dropped.
    logic we_ch;
    assign we_ch = cfg_we && (cfg_ch == CH_IDX_W'(i));

    module_canal_pulsos #(
      .CNT_W         (CNT_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) u_canal (
      .clk        (clk),
      .rst        (rst),
      .en         (ch_en[i]),
      .start      (start[i]),
      .cfg_we     (we_ch),
      .cfg_period (cfg_period),
      .cfg_oneshot(cfg_oneshot),
      .tick       (tick[i]),
      .busy       (busy[i])
    );
  end

endmodule

// File: tb/tb_module_generador_pulsos_multicanal.sv
// Self-checking bench for the multi-channel tick strobe generator (N_CH=4, CNT_W=8, P=5).
module tb_module_generador_pulsos_multicanal;

  logic       clk = 1'b0;
  logic       rst, cfg_we, cfg_oneshot;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period;
  logic [3:0] ch_en, start, tick, busy;

  always #5 clk = ~clk;

  module_generador_pulsos_multicanal #(
    .N_CH          (4),
    .CNT_W         (8),
    .DEFAULT_PERIOD(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_oneshot(cfg_oneshot),
    .ch_en      (ch_en),
    .start      (start),
    .tick       (tick),
    .busy       (busy)
  );

  typedef struct {
    logic [3:0] t;
    logic [3:0] b;
    string      name;
    int         k;
  } exp_t;

  typedef struct {
    logic [3:0] en;
    logic [3:0] et;
    logic [3:0] eb;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Drive one edge's inputs, queue the expected outputs for the following cycle, then compare.
  task automatic cyc(input logic r, input logic [3:0] en, input logic [3:0] st,
                     input logic we, input logic [1:0] ch, input logic [7:0] p,
                     input logic os, input logic [3:0] et, input logic [3:0] eb,
                     input string nm, input int k);
    exp_t e;
    rst = r; ch_en = en; start = st; cfg_we = we;
    cfg_ch = ch; cfg_period = p; cfg_oneshot = os;
    sb.push_back('{et, eb, nm, k});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (tick !== e.t || busy !== e.b) begin
      errors++;
      $display("FAIL %s cycle %0d: tick=%b busy=%b, expected tick=%b busy=%b",
               e.name, e.k, tick, busy, e.t, e.b);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 4'b0, 4'b0, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0, 4'b0, "reset", i);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] p, input logic os);
    cyc(1'b0, 4'b0, 4'b0, 1'b1, ch, p, os, 4'b0, 4'b0, "cfg_idle", 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[17];
    logic [3:0] et, eb, en;

    // 1: default period 5 on channel 0 only.
    for (int k = 0; k < 17; k++) begin
      tbl[k].en = 4'b0001;
      tbl[k].et = (k > 0 && k % 5 == 0) ? 4'b0001 : 4'b0000;
      tbl[k].eb = 4'b0001;
    end
    do_reset();
    for (int k = 0; k < 17; k++)
      cyc(1'b0, tbl[k].en, 4'b0, 1'b0, 2'd0, 8'd0, 1'b0, tbl[k].et, tbl[k].eb, "t1_default", k);

    // 2: period change while running takes effect after the in-flight period.
    do_reset();
    cfg(2'd0, 8'd3, 1'b0);
    for (int k = 0; k < 20; k++) begin
      et = (k == 3 || k == 6 || k == 12 || k == 18) ? 4'b0001 : 4'b0000;
      cyc(1'b0, 4'b0001, 4'b0, (k == 4), 2'd0, 8'd6, 1'b0, et, 4'b0001, "t2_shadow", k);
    end

    // 3: one-shot with a redundant start while running.
    do_reset();
    cfg(2'd1, 8'd4, 1'b1);
    for (int k = 0; k < 11; k++) begin
      et = (k == 4) ? 4'b0010 : 4'b0000;
      eb = (k < 4) ? 4'b0010 : 4'b0000;
      cyc(1'b0, 4'b0010, (k == 0 || k == 2) ? 4'b0010 : 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0,
          et, eb, "t3_oneshot", k);
    end

    // 4: P=1 ticks every cycle; P=0 never runs.
    do_reset();
    cfg(2'd2, 8'd1, 1'b0);
    cfg(2'd3, 8'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      et = (k >= 1) ? 4'b0100 : 4'b0000;
      cyc(1'b0, 4'b1100, 4'b0, 1'b0, 2'd0, 8'd0, 1'b0, et, 4'b0100, "t4_p1_p0", k);
    end

    // 5: enable drop mid-count restarts the full period.
    do_reset();
    for (int k = 0; k < 19; k++) begin
      en = (k >= 3 && k <= 6) ? 4'b0000 : 4'b0001;
      et = (k == 12 || k == 17) ? 4'b0001 : 4'b0000;
      cyc(1'b0, en, 4'b0, 1'b0, 2'd0, 8'd0, 1'b0, et, en, "t5_en_drop", k);
    end

    // 6: reset mid-count restores default periods; a write under reset is ignored.
    do_reset();
    cfg(2'd0, 8'd3, 1'b0);
    for (int k = 0; k < 4; k++)
      cyc(1'b0, 4'b1111, 4'b0, 1'b0, 2'd0, 8'd0, 1'b0, (k == 3) ? 4'b0001 : 4'b0000,
          4'b1111, "t6_pre_rst", k);
    cyc(1'b1, 4'b1111, 4'b0, 1'b1, 2'd1, 8'd2, 1'b0, 4'b0, 4'b0, "t6_rst", 4);
    for (int k = 5; k < 12; k++)
      cyc(1'b0, 4'b1111, 4'b0, 1'b0, 2'd0, 8'd0, 1'b0, (k == 10) ? 4'b1111 : 4'b0000,
          4'b1111, "t6_post_rst", k);

    // 7: last pending write wins; a write in the wrap cycle applies to the next period.
    do_reset();
    cfg(2'd0, 8'd3, 1'b0);
    for (int k = 0; k < 17; k++) begin
      et = (k == 3 || k == 7 || k == 11 || k == 13 || k == 15) ? 4'b0001 : 4'b0000;
      cyc(1'b0, 4'b0001, 4'b0, (k == 1 || k == 2 || k == 11), 2'd0,
          (k == 1) ? 8'd7 : (k == 2) ? 8'd4 : 8'd2, 1'b0, et, 4'b0001, "t7_last_write", k);
    end

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
